// File: rtl/matmul_scheduler.sv
// matmul_scheduler: walks the i/j/k loops of a small C = A*B job, issuing MAC, accumulator-clear and C-write strobes.
// Strobes are registered, so stall_i sampled at one edge freezes the MAC step in the following cycle.
module matmul_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [1:0] n_dim_i,
    input  logic [1:0] k_dim_i,
    input  logic [1:0] m_dim_i,
    input  logic       stall_i,
    output logic [1:0] row_o,
    output logic [1:0] col_o,
    output logic [1:0] k_o,
    output logic       mac_valid_o,
    output logic       clear_acc_o,
    output logic       write_en_o,
    output logic [3:0] c_idx_o,
    output logic       busy_o,
    output logic       finish_o,
    output logic       err_o
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

    state_t     state;
    logic [1:0] n_last, k_last, m_last, i, j, k;
    logic       start_q, armed, ovf, start_edge;

    // armed stays low until start_i is seen low, so a start held through reset cannot launch a job
    assign start_edge = start_i & ~start_q & armed;
    assign ovf = int'(n_dim_i) >= MAX_DIM || int'(k_dim_i) >= MAX_DIM || int'(m_dim_i) >= MAX_DIM;

    assign row_o   = i;
    assign col_o   = j;
    assign k_o     = k;
    assign c_idx_o = 4'(int'(i) * MAX_DIM + int'(j));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            n_last      <= '0;
            k_last      <= '0;
            m_last      <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            start_q     <= 1'b0;
            armed       <= 1'b0;
            mac_valid_o <= 1'b0;
            clear_acc_o <= 1'b0;
            write_en_o  <= 1'b0;
            busy_o      <= 1'b0;
            finish_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            start_q     <= start_i;
            armed       <= armed | ~start_i;
            mac_valid_o <= 1'b0;
            clear_acc_o <= 1'b0;
            write_en_o  <= 1'b0;
            finish_o    <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    state  <= LOAD;
                    busy_o <= 1'b1;
                    err_o  <= 1'b0;
                end
                LOAD: begin
                    n_last <= n_dim_i;
                    k_last <= k_dim_i;
                    m_last <= m_dim_i;
                    i      <= '0;
                    j      <= '0;
                    k      <= '0;
                    if (ovf) begin
                        err_o    <= 1'b1;
                        finish_o <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mac_valid_o <= ~stall_i;
                        clear_acc_o <= ~stall_i;
                        state       <= MAC;
                    end
                end
                // mac_valid_o marks a cycle that actually stepped; a low value here means we were stalled
                MAC: if (!mac_valid_o) begin
                    mac_valid_o <= ~stall_i;
                    clear_acc_o <= ~stall_i & (k == 2'd0);
                end else if (k == k_last) begin
                    k          <= '0;
                    write_en_o <= 1'b1;
                    state      <= WRITE;
                end else begin
                    k           <= k + 2'd1;
                    mac_valid_o <= ~stall_i;
                end
                WRITE: begin
                    j <= (j == m_last) ? 2'd0 : j + 2'd1;
                    if (j == m_last) i <= i + 2'd1;
                    if (i == n_last && j == m_last) begin
                        finish_o <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mac_valid_o <= ~stall_i;
                        clear_acc_o <= ~stall_i;
                        state       <= MAC;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: directed and random jobs checked cycle by cycle against a loop-nest work-list model.
module tb_matmul_scheduler;
    localparam int MAX_DIM = 2;

    logic       clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, stall_i = 1'b0;
    logic [1:0] n_dim_i = '0, k_dim_i = '0, m_dim_i = '0;
    logic [1:0] row_o, col_o, k_o;
    logic       mac_valid_o, clear_acc_o, write_en_o, busy_o, finish_o, err_o;
    logic [3:0] c_idx_o;
    int         pass_cnt = 0, fail_cnt = 0, total = 0;
    bit         last_err = 1'b0;

    typedef struct {bit is_mac; int i; int j; int k;} item_t;

    always #5 clk_i = ~clk_i;

    matmul_scheduler dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i), .stall_i(stall_i),
        .row_o(row_o), .col_o(col_o), .k_o(k_o),
        .mac_valid_o(mac_valid_o), .clear_acc_o(clear_acc_o), .write_en_o(write_en_o),
        .c_idx_o(c_idx_o), .busy_o(busy_o), .finish_o(finish_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {busy_o, mac_valid_o, clear_acc_o, write_en_o, finish_o, err_o};
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk(tag, 32'(flags()), {26'b0, 5'b0, last_err});
    endtask

    // Runs one job from a fresh start edge; abort_at > 0 pulses reset in that cycle instead of finishing.
    task automatic run_job(input logic [1:0] n, input logic [1:0] kd, input logic [1:0] m,
                           input int sp, input int st_from, input int st_len,
                           input bit noise, input int exp_fin, input int abort_at);
        item_t it;
        item_t items[$];
        int    nn = int'(n) + 1, kk = int'(kd) + 1, mm = int'(m) + 1;
        bit    ovf = nn > MAX_DIM || kk > MAX_DIM || mm > MAX_DIM;
        int    idx = 0, nstall = 0, fin_t = -1;
        bit    stall_prev = 1'b0, stall_now;
        if (!ovf)
            for (int a = 0; a < nn; a++)
                for (int b = 0; b < mm; b++) begin
                    for (int c = 0; c < kk; c++) items.push_back('{1'b1, a, b, c});
                    items.push_back('{1'b0, a, b, 0});
                end
        n_dim_i = n; k_dim_i = kd; m_dim_i = m;
        start_i = 1'b1;
        stall_i = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            next_cycle();
            if (t == abort_at) begin
                start_i = 1'b1;
                rst_ni  = 1'b0;
                #1;
                chk("reset_outputs", 32'({flags(), row_o, col_o, k_o, c_idx_o}), 32'h0);
                next_cycle();
                chk("reset_held", 32'(flags()), 32'h0);
                rst_ni = 1'b1;
                last_err = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    next_cycle();
                    check_idle("no_launch_after_reset");
                end
                start_i = 1'b0;
                next_cycle();
                return;
            end
            if (t == 1) chk("load", 32'(flags()), {26'b0, 6'b100000});
            else if (idx < items.size()) begin
                it = items[idx];
                if (it.is_mac && stall_prev) begin
                    chk("stalled", 32'(flags()), {26'b0, 6'b100000});
                    nstall++;
                end else if (it.is_mac) begin
                    chk("mac", 32'(flags()), {26'b0, 2'b11, it.k == 0, 3'b000});
                    idx++;
                end else begin
                    chk("write", 32'(flags()), {26'b0, 6'b100100});
                    chk("c_idx", 32'(c_idx_o), 32'(it.i * MAX_DIM + it.j));
                    idx++;
                end
                chk("indices", 32'({row_o, col_o, k_o}), 32'({2'(it.i), 2'(it.j), 2'(it.k)}));
            end else begin
                chk("done", 32'(flags()), {26'b0, 5'b10001, ovf});
                fin_t = t;
                start_i = 1'b0;
                stall_i = 1'b0;
                break;
            end
            stall_now = (t >= st_from && t < st_from + st_len) || ($urandom_range(99) < sp);
            stall_i = stall_now;
            stall_prev = stall_now;
            if (noise && t >= 2) begin
                start_i = 1'($urandom_range(1));
                n_dim_i = 2'($urandom_range(3));
                k_dim_i = 2'($urandom_range(3));
                m_dim_i = 2'($urandom_range(3));
            end
        end
        if (fin_t < 0) begin
            chk("finish_timeout", 32'(fin_t), 32'hFFFF_FFFF - 1);
            start_i = 1'b0;
        end
        if (exp_fin >= 0) chk("finish_cycle", 32'(fin_t), 32'(exp_fin));
        chk("latency", 32'(fin_t), 32'(ovf ? 2 : 2 + nn * mm * (kk + 1) + nstall));
        last_err = ovf;
        for (int w = 0; w < 2; w++) begin
            next_cycle();
            check_idle("idle_after_job");
        end
    endtask

    initial begin
        #2;
        chk("reset_state", 32'({flags(), row_o, col_o, k_o, c_idx_o}), 32'h0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        check_idle("idle_after_reset");
        run_job(2'd1, 2'd1, 2'd1, 0, 0, 0, 1'b0, 14, 0);
        run_job(2'd0, 2'd0, 2'd0, 0, 0, 0, 1'b0, 4, 0);
        run_job(2'd0, 2'd2, 2'd0, 0, 0, 0, 1'b0, 2, 0);
        run_job(2'd1, 2'd1, 2'd1, 0, 0, 0, 1'b0, 14, 0);
        run_job(2'd1, 2'd1, 2'd1, 0, 2, 3, 1'b0, 17, 0);
        run_job(2'd3, 2'd0, 2'd1, 0, 0, 0, 1'b0, 2, 0);
        run_job(2'd1, 2'd0, 2'd1, 20, 0, 0, 1'b1, -1, 0);
        run_job(2'd1, 2'd1, 2'd1, 0, 0, 0, 1'b0, -1, 5);
        run_job(2'd0, 2'd1, 2'd1, 0, 0, 0, 1'b0, 8, 0);
        for (int r = 0; r < 20; r++)
            run_job(2'($urandom_range(2)), 2'($urandom_range(2)), 2'($urandom_range(2)),
                    $urandom_range(40), 0, 0, 1'($urandom_range(1)), -1, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
